pc_next_unit: RTL
=================

Name: pc_next_unit

Overview:
Producer side of the program-counter register. Each cycle it decides whether the PC advances (pc_write) and to what value (new_pc):
- sequential PC+4, or
- a branch, jump or jump-register redirect.

It also runs a request/acknowledge handshake with instruction memory, so the PC only advances once the current fetch has completed. Redirects that arrive mid-fetch are buffered, and an IF/ID flush is issued for every accepted redirect.

Parameters:
- N, 32, datapath/address width.
- RESET_PC, 32'h0040_0000, PC value presented on new_pc while in IDLE. Must match the PC register's reset value.

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-low
- pc_value  input  N  current PC from the PC register
- stall  input  1  hazard-unit stall; blocks PC advance
- branch_taken  input  1  resolved taken branch this cycle
- branch_target  input  N  branch destination
- jump  input  1  J/JAL this cycle
- jump_target  input  N  jump destination
- jr  input  1  JR/JALR this cycle
- jr_target  input  N  register destination
- fetch_ack  input  1  instruction memory completed the current fetch (1-cycle pulse)
- fetch_req  output  1  fetch of pc_value outstanding
- new_pc  output  N  next PC value to the PC register
- pc_write  output  1  PC register load enable
- flush  output  1  squash IF/ID; 1-cycle pulse
- redirect_pending  output  1  a buffered redirect is waiting
- misaligned  output  1  1-cycle pulse: accepted target had [1:0] != 0

Behaviour:
- Reset (reset = 0, async):
  - state = IDLE, pending = 0, pend_target = 0.
  - Outputs: fetch_req = 0, pc_write = 0, flush = 0, misaligned = 0, redirect_pending = 0, new_pc = RESET_PC.
- States:
  - IDLE: first clock after reset release goes to FETCH. No outputs asserted.
  - FETCH: fetch_req = 1.
    - fetch_ack = 1 and stall = 0: pc_write = 1, stay in FETCH.
    - fetch_ack = 1 and stall = 1: go to HOLD.
    - Otherwise: stay in FETCH.
  - HOLD: fetch_req = 0, pc_write = 0.
    - stall = 0: pc_write = 1 that cycle, go to FETCH.
- Redirect select (same cycle, combinational):
  - Priority: branch_taken > jr > jump.
  - sel_target is the chosen target with bits [1:0] forced to 0.
  - misaligned = 1 if the original target's [1:0] != 0 and that redirect is accepted.
- Next-PC select when pc_write = 1, in priority order:
  1. Same-cycle redirect → sel_target.
  2. Else pending = 1 → pend_target.
  3. Else pc_value + 4, truncated to N bits (0xFFFF_FFFC + 4 = 0).
- When pc_write = 0, new_pc still shows the select result; the PC register ignores it.
- Redirect with pc_write = 0 (fetch outstanding or stalled):
  - pending <= 1, pend_target <= sel_target.
  - A later redirect overwrites pend_target.
- Pending clears on the cycle pc_write = 1, unless a new redirect arrives that cycle; the new redirect is then used and pending still clears.
- flush = 1 in any cycle a redirect is accepted (applied or buffered), IDLE excluded. Flush is never asserted for sequential advance.
- Redirects are ignored in IDLE.
- redirect_pending = registered pending.
- Async reset mid-fetch or with pending set: everything returns to reset values immediately; no pc_write.

Decomposition:
- Shared package, pc_pkg:
  - State encoding: IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2.
  - Constants PC_RESET = 32'h0040_0000 and PC_INC = 4.
- One natural sub-module: pc_redirect_mux. Pure combinational; priority select plus alignment check.
- FSM and pending register stay in the top module.

Test Plan:
- Reset release, pc_value = 0x00400000, fetch_ack on the 3rd FETCH cycle → pc_write pulses once, new_pc = 0x00400004, flush = 0.
- FETCH with fetch_ack = 1 and stall = 1 for 2 cycles, then stall = 0 → HOLD for 2 cycles with pc_write = 0, fetch_req = 0; then pc_write = 1, new_pc = pc_value + 4.
- branch_taken = 1 to 0x00400100 while fetch unacked → flush pulses 1 cycle, redirect_pending = 1; next fetch_ack gives pc_write = 1, new_pc = 0x00400100, redirect_pending drops to 0.
- branch_taken (0x00400200), jr (0x00400300) and jump (0x00400400) in the same cycle as fetch_ack → new_pc = 0x00400200, flush = 1.
- jump_target = 0x00400102 with fetch_ack → new_pc = 0x00400100, misaligned = 1 for 1 cycle. Separately, pc_value = 0xFFFFFFFC sequential → new_pc = 0x00000000.
- Reset asserted while pending = 1 → redirect_pending, fetch_req, pc_write drop to 0 immediately; after release, 1 IDLE cycle then fetch_req = 1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter next-value logic.
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } pc_state_e;

    localparam logic [31:0] PC_RESET = 32'h0040_0000;
    localparam int unsigned PC_INC   = 4;

endpackage

// File: rtl/pc_redirect_mux.sv
// Priority select among branch, jump-register and jump targets, with word alignment check.
module pc_redirect_mux #(
    parameter int unsigned N = 32
) (
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         jr,
    input  logic [N-1:0] jr_target,
    input  logic         jump,
    input  logic [N-1:0] jump_target,
    output logic         redirect,
    output logic [N-1:0] sel_target,
    output logic         target_misaligned
);

    logic [N-1:0] raw_target;

    always_comb begin
        redirect   = 1'b0;
        raw_target = '0;
        if (branch_taken) begin
            redirect   = 1'b1;
            raw_target = branch_target;
        end else if (jr) begin
            redirect   = 1'b1;
            raw_target = jr_target;
        end else if (jump) begin
            redirect   = 1'b1;
            raw_target = jump_target;
        end
    end

    // Low bits are dropped on the target but reported so software faults can be traced.
    assign sel_target        = {raw_target[N-1:2], 2'b00};
    assign target_misaligned = redirect && (raw_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC producer: fetch handshake FSM, redirect buffering and IF/ID flush generation.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = N'(PC_RESET)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pc_value,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         jump,
    input  logic [N-1:0] jump_target,
    input  logic         jr,
    input  logic [N-1:0] jr_target,
    input  logic         fetch_ack,
    output logic         fetch_req,
    output logic [N-1:0] new_pc,
    output logic         pc_write,
    output logic         flush,
    output logic         redirect_pending,
    output logic         misaligned
);

    pc_state_e    state, next_state;
    logic         pending;
    logic [N-1:0] pend_target;
    logic         redirect;
    logic [N-1:0] sel_target;
    logic         target_misaligned;
    logic         accept;

    pc_redirect_mux #(.N(N)) u_mux (
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .jr                (jr),
        .jr_target         (jr_target),
        .jump              (jump),
        .jump_target       (jump_target),
        .redirect          (redirect),
        .sel_target        (sel_target),
        .target_misaligned (target_misaligned)
    );

    assign accept = redirect && (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        fetch_req  = 1'b0;
        pc_write   = 1'b0;
        case (state)
            IDLE: next_state = FETCH;
            FETCH: begin
                fetch_req = 1'b1;
                if (fetch_ack && !stall) begin
                    pc_write = 1'b1;
                end else if (fetch_ack && stall) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    pc_write   = 1'b1;
                    next_state = FETCH;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        new_pc = pc_value + N'(PC_INC);
        if (state == IDLE) begin
            new_pc = RESET_PC;
        end else if (redirect) begin
            new_pc = sel_target;
        end else if (pending) begin
            new_pc = pend_target;
        end
    end

    // A redirect landing on the pc_write cycle is consumed directly, so pending still clears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending     <= 1'b0;
            pend_target <= '0;
        end else if (pc_write) begin
            pending <= 1'b0;
        end else if (accept) begin
            pending     <= 1'b1;
            pend_target <= sel_target;
        end
    end

    assign flush            = accept;
    assign misaligned       = accept && target_misaligned;
    assign redirect_pending = pending;

endmodule
